axi_master_bridge: RTL and testbench
====================================

AXI_MASTER_BRIDGE -- requirements
Module: axi_master_bridge

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 ren_i  in  1  read request level, held until the transaction's final rdata_valid_o.
REQ-004 raddr_i  in  32  read start address, valid while ren_i.
REQ-005 rlen_i  in  4  read beats minus 1 (0 = single, 7 = line).
REQ-006 rsel_i  in  4  read byte select, selects arsize.
REQ-007 rdata_o  out  32  read beat data (passthrough of rdata).
REQ-008 rdata_valid_o  out  1  one pulse per accepted read beat.
REQ-009 wen_i  in  1  write request level, held until the final wdata_resp_o.
REQ-010 waddr_i  in  32  write start address.
REQ-011 wdata_i  in  32  current beat data; requester advances it after each wdata_resp_o.
REQ-012 wlen_i  in  4  write beats minus 1.
REQ-013 wsel_i  in  4  write byte strobe.
REQ-014 wdata_resp_o  out  1  one pulse per completed write beat.
REQ-015 araddr/arlen[7:0]/arsize[2:0]/arvalid  out  AXI AR payload and valid; arready  in  1.
REQ-016 rdata[31:0]/rlast/rvalid  in  AXI R channel; rready  out  1.
REQ-017 awaddr/awlen[7:0]/awsize[2:0]/awvalid  out  AXI AW payload and valid; awready  in  1.
REQ-018 wdata[31:0]/wstrb[3:0]/wlast/wvalid  out  AXI W channel; wready  in  1.
REQ-019 bvalid  in  1; bready  out  1.
- Constant ports (ID=0, burst=INCR, lock/cache/prot=0) are tied at top level, not in this block.

Function
REQ-020 Read FSM SHALL be R_IDLE -> R_AR (on ren_i) -> R_DATA (arvalid&arready) -> R_END (rvalid&rready&rlast) -> R_IDLE (unconditional).
- R_END stops a held ren_i from re-issuing AR.
REQ-021 Address and size capture:
- On R_IDLE->R_AR: capture raddr_i; arlen = {4'b0, rlen_i}.
- arsize = 2 for rsel 1111, 1 for 0011/1100, 0 for a single bit set.
- arvalid = (state == R_AR).
REQ-022 In R_DATA:
- rready = 1; rdata_valid_o = rvalid (combinational, zero latency).
- rdata_o = rdata; rready = 0 in all other states.
REQ-023 Write FSM SHALL be W_IDLE -> W_AW (on wen_i) -> W_DATA (awvalid&awready) -> W_B (W handshake with wlast) -> W_END (bvalid) -> W_IDLE.
- Address, length, size (same rule as REQ-021) and strobe are captured on leaving W_IDLE.
REQ-024 In W_DATA:
- wvalid = 1; wdata = wdata_i; wstrb = captured wsel.
- 4-bit beat counter counts from 0; wlast = (count == captured wlen).
- Counter increments on each wvalid&wready.
REQ-025 wdata_resp_o:
- Pulses combinationally on the wvalid&wready of every non-last beat.
- For the last beat, timing is per REQ-029.
- Exactly wlen+1 pulses per transaction.
REQ-026 bready = (state == W_B).
- bresp/rresp are ignored.
REQ-027 Read and write FSMs SHALL run independently; simultaneous ren_i and wen_i both proceed.

Reset
REQ-028 resetn low, including mid-burst:
- Both FSMs go to IDLE and the beat counter clears.
- All valid/ready/pulse outputs are 0.
- Captured address/length/size registers are 0.
- The transaction is abandoned; no resumption.

Configuration
REQ-029 WRESP_WAIT_B_EN:
- Defined: the last-beat wdata_resp_o pulses on bvalid&bready in W_B, guaranteeing write completion before the requester frees.
- Undefined: the last-beat pulse occurs on the wlast W handshake; W_B still completes B silently, and no new AW is issued until W_END.

Verification
REQ-030 ren_i=1, raddr_i=0x1FC0_0020, rlen_i=7, rsel_i=1111, arready after 2 cycles, 8 rvalid beats:
- araddr=0x1FC0_0020, arlen=7, arsize=2.
- Exactly 8 rdata_valid_o pulses, single AR.
REQ-031 Single-byte read, rlen_i=0, rsel_i=0100, rvalid with rlast in the cycle after AR handshake:
- arsize=0; one rdata_valid_o pulse carrying rdata.
REQ-032 Line write, wlen_i=7, wsel_i=1111, wready toggling 1/0, bvalid 3 cycles after last beat:
- Each W beat equals the wdata_i presented in that cycle.
- wlast on beat 7 only; 8 wdata_resp_o pulses, the last coincident with bvalid (macro defined).
REQ-033 Same stimulus with macro undefined:
- 8th wdata_resp_o occurs on the wlast handshake.
- bready is still asserted until bvalid.
REQ-034 Read and write requested in the same cycle:
- AR and AW are both issued; both complete with correct pulse counts.
REQ-035 resetn asserted during read beat 3:
- All outputs go to 0 immediately.
- After release with ren_i held, a fresh AR is issued.

Source files
------------

// File: rtl/axi_master_bridge.sv
// ---------------------------------------------------------------------------
// axi_master_bridge
//
// Converts a simple level-held read/write request interface into AXI4
// master transactions. Read and write paths are independent FSMs and may
// run concurrently.
//
// Optional feature macro: WRESP_WAIT_B_EN
//   defined   : the last-beat wdata_resp_o pulse is held back until the B
//               handshake, so the requester only frees once the write is done.
//   undefined : the last-beat pulse occurs on the wlast W handshake; the B
//               response is still collected before a new AW can be issued.
//
// Ports
//   clk, resetn        : clock, asynchronous active-low reset
//   ren_i/raddr_i/rlen_i/rsel_i        : read request (level, beats-1, byte sel)
//   rdata_o/rdata_valid_o              : read beat data and per-beat strobe
//   wen_i/waddr_i/wdata_i/wlen_i/wsel_i: write request and current beat data
//   wdata_resp_o                       : per-beat write completion strobe
//   araddr/arlen/arsize/arvalid/arready: AXI AR channel
//   rdata/rlast/rvalid/rready          : AXI R channel
//   awaddr/awlen/awsize/awvalid/awready: AXI AW channel
//   wdata/wstrb/wlast/wvalid/wready    : AXI W channel
//   bvalid/bready                      : AXI B channel
// ---------------------------------------------------------------------------
module axi_master_bridge (
  input  logic        clk,
  input  logic        resetn,
  // read requester side
  input  logic        ren_i,
  input  logic [31:0] raddr_i,
  input  logic [3:0]  rlen_i,
  input  logic [3:0]  rsel_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  // write requester side
  input  logic        wen_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wlen_i,
  input  logic [3:0]  wsel_i,
  output logic        wdata_resp_o,
  // AXI AR
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  // AXI R
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI AW
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  // AXI W
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI B
  input  logic        bvalid,
  output logic        bready
);

  // Byte-select pattern to AXI size: full word, aligned half, single byte.
  // Unlisted patterns fall back to a full-word access.
  function automatic logic [2:0] sel_to_size(input logic [3:0] sel);
    logic [2:0] size;
    case (sel)
      4'b1111:                            size = 3'd2;
      4'b0011, 4'b1100:                   size = 3'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 3'd0;
      default:                            size = 3'd2;
    endcase
    return size;
  endfunction

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_DATA,
    R_END
  } rstate_t;

  rstate_t     rstate_q, rstate_d;
  logic [31:0] raddr_q,  raddr_d;
  logic [3:0]  rlen_q,   rlen_d;
  logic [2:0]  rsize_q,  rsize_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    case (rstate_q)
      R_IDLE: begin
        if (ren_i) begin
          rstate_d = R_AR;
          raddr_d  = raddr_i;
          rlen_d   = rlen_i;
          rsize_d  = sel_to_size(rsel_i);
        end
      end
      R_AR: begin
        if (arready) rstate_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid && rlast) rstate_d = R_END;
      end
      // One dead cycle so a still-held ren_i cannot start a second AR.
      R_END:   rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  logic r_in_data;

  always_comb begin
    r_in_data     = (rstate_q == R_DATA);
    araddr        = raddr_q;
    arlen         = {4'b0000, rlen_q};
    arsize        = rsize_q;
    arvalid       = (rstate_q == R_AR);
    rready        = r_in_data;
    rdata_valid_o = r_in_data && rvalid;
    rdata_o       = r_in_data ? rdata : '0;
  end

  // -------------------------------------------------------------------------
  // Write path
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    W_IDLE,
    W_AW,
    W_DATA,
    W_B,
    W_END
  } wstate_t;

  wstate_t     wstate_q, wstate_d;
  logic [31:0] waddr_q,  waddr_d;
  logic [3:0]  wlen_q,   wlen_d;
  logic [2:0]  wsize_q,  wsize_d;
  logic [3:0]  wstrb_q,  wstrb_d;
  logic [3:0]  wcnt_q,   wcnt_d;

  logic w_in_data;
  logic w_last_beat;
  logic w_hs;
  logic b_hs;

  always_comb begin
    w_in_data   = (wstate_q == W_DATA);
    w_last_beat = w_in_data && (wcnt_q == wlen_q);
    w_hs        = w_in_data && wready;
    b_hs        = (wstate_q == W_B) && bvalid;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wstrb_q  <= '0;
      wcnt_q   <= '0;
    end else begin
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wstrb_q  <= wstrb_d;
      wcnt_q   <= wcnt_d;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wsize_d  = wsize_q;
    wstrb_d  = wstrb_q;
    wcnt_d   = wcnt_q;
    case (wstate_q)
      W_IDLE: begin
        if (wen_i) begin
          wstate_d = W_AW;
          waddr_d  = waddr_i;
          wlen_d   = wlen_i;
          wsize_d  = sel_to_size(wsel_i);
          wstrb_d  = wsel_i;
          wcnt_d   = '0;
        end
      end
      W_AW: begin
        if (awready) wstate_d = W_DATA;
      end
      W_DATA: begin
        if (w_hs) begin
          if (w_last_beat) begin
            wstate_d = W_B;
            wcnt_d   = '0;
          end else begin
            wcnt_d   = wcnt_q + 4'd1;
          end
        end
      end
      W_B: begin
        if (bvalid) wstate_d = W_END;
      end
      W_END:   wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  logic resp_last;

`ifdef WRESP_WAIT_B_EN
  always_comb resp_last = b_hs;
`else
  always_comb resp_last = w_hs && w_last_beat;
`endif

  always_comb begin
    awaddr       = waddr_q;
    awlen        = {4'b0000, wlen_q};
    awsize       = wsize_q;
    awvalid      = (wstate_q == W_AW);
    wvalid       = w_in_data;
    wdata        = w_in_data ? wdata_i : '0;
    wstrb        = wstrb_q;
    wlast        = w_last_beat;
    bready       = (wstate_q == W_B);
    wdata_resp_o = (w_hs && !w_last_beat) || resp_last;
  end

endmodule

// File: tb/tb_axi_master_bridge.sv
module tb_axi_master_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ren_i;
  logic [31:0] raddr_i;
  logic [3:0]  rlen_i, rsel_i;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        wen_i;
  logic [31:0] waddr_i, wdata_i;
  logic [3:0]  wlen_i, wsel_i;
  logic        wdata_resp_o;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  axi_master_bridge dut (
    .clk(clk), .resetn(resetn),
    .ren_i(ren_i), .raddr_i(raddr_i), .rlen_i(rlen_i), .rsel_i(rsel_i),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .wen_i(wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .wlen_i(wlen_i),
    .wsel_i(wsel_i), .wdata_resp_o(wdata_resp_o),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
    .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] rq[$];
  logic [31:0] wq[$];

  // Handshake / pulse counters sampled on the active edge.
  int ar_hs = 0, aw_hs = 0, r_pulse = 0, w_pulse = 0;
  always @(posedge clk) begin
    if (arvalid && arready) ar_hs++;
    if (awvalid && awready) aw_hs++;
    if (rdata_valid_o)      r_pulse++;
    if (wdata_resp_o)       w_pulse++;
  end

`ifdef WRESP_WAIT_B_EN
  localparam bit WAIT_B = 1'b1;
`else
  localparam bit WAIT_B = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the caller at negedge+1 with the requested valid observed high.
  task automatic wait_valid(input bit is_aw, input string tag);
    int k;
    k = 0;
    forever begin
      @(negedge clk); #1;
      if (is_aw ? awvalid : arvalid) break;
      k++;
      if (k > 10) begin
        chk(tag, 32'd0, 32'd1);
        break;
      end
    end
  endtask

  // Drives n R beats (rlast on the final one) and scoreboards rdata_o.
  task automatic read_beats(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      arready = 1'b0;
      rvalid  = 1'b1;
      rdata   = $urandom;
      rlast   = (i == n - 1);
      rq.push_back(rdata);
      #1;
      chk("rready", rready, 1);
      chk("rdata_valid", rdata_valid_o, 1);
      if (rdata_valid_o && rq.size() > 0) chk("rdata", rdata_o, rq.pop_front());
    end
    @(negedge clk);
    rvalid = 1'b0;
    rlast  = 1'b0;
    ren_i  = 1'b0;
    #1;
    chk("r_end_no_ar", arvalid, 0);
    chk("r_end_rready", rready, 0);
  endtask

  initial begin
    int a0, aw0, p0, wp0, b, ri, wi;
    bit bdone;
    logic [31:0] d;

    resetn = 1'b0; ren_i = 0; raddr_i = '0; rlen_i = '0; rsel_i = '0;
    wen_i = 0; waddr_i = '0; wdata_i = '0; wlen_i = '0; wsel_i = '0;
    arready = 0; awready = 0; rdata = '0; rlast = 0; rvalid = 0;
    wready = 0; bvalid = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awlen", awlen, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Line read, arready delayed by 2 cycles
    a0 = ar_hs; p0 = r_pulse;
    @(negedge clk);
    ren_i = 1; raddr_i = 32'h1FC0_0020; rlen_i = 4'd7; rsel_i = 4'b1111;
    wait_valid(1'b0, "ar_timeout_line");
    chk("line_araddr", araddr, 32'h1FC0_0020);
    chk("line_arlen", arlen, 7);
    chk("line_arsize", arsize, 2);
    @(negedge clk); #1;
    chk("line_ar_hold", arvalid, 1);
    @(negedge clk);
    arready = 1'b1;
    read_beats(8);
    @(negedge clk);
    chk("line_ar_count", ar_hs - a0, 1);
    chk("line_pulses", r_pulse - p0, 8);

    // Single-byte read
    a0 = ar_hs; p0 = r_pulse;
    ren_i = 1; raddr_i = 32'h0000_0013; rlen_i = 4'd0; rsel_i = 4'b0100;
    wait_valid(1'b0, "ar_timeout_byte");
    chk("byte_arsize", arsize, 0);
    chk("byte_arlen", arlen, 0);
    arready = 1'b1;
    read_beats(1);
    @(negedge clk);
    chk("byte_pulses", r_pulse - p0, 1);
    chk("byte_ar_count", ar_hs - a0, 1);

    // Line write, wready toggling, bvalid 3 cycles after the last beat
    aw0 = aw_hs; wp0 = w_pulse;
    wen_i = 1; waddr_i = 32'h2000_0100; wlen_i = 4'd7; wsel_i = 4'b1111;
    wait_valid(1'b1, "aw_timeout_line");
    chk("line_awaddr", awaddr, 32'h2000_0100);
    chk("line_awlen", awlen, 7);
    chk("line_awsize", awsize, 2);
    awready = 1'b1;
    b = 0;
    for (int c = 0; c < 40 && b < 8; c++) begin
      @(negedge clk);
      awready = 1'b0;
      wready  = (c % 2 == 0);
      d       = $urandom;
      wdata_i = d;
      if (wready) wq.push_back(d);
      #1;
      chk("w_valid", wvalid, 1);
      chk("w_last", wlast, (b == 7));
      chk("w_strb", wstrb, 4'hF);
      if (wready) begin
        if (wq.size() > 0) chk("w_data", wdata, wq.pop_front());
        chk("w_resp", wdata_resp_o, (b < 7) ? 1 : !WAIT_B);
        b++;
      end else begin
        chk("w_resp_idle", wdata_resp_o, 0);
      end
    end
    chk("w_beats_done", b, 8);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      wready = 1'b0;
      bvalid = (c == 2);
      #1;
      chk("b_ready", bready, 1);
      chk("b_resp", wdata_resp_o, (c == 2) ? WAIT_B : 1'b0);
    end
    @(negedge clk);
    bvalid = 1'b0;
    wen_i  = 1'b0;
    #1;
    chk("w_end_bready", bready, 0);
    chk("w_end_awvalid", awvalid, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("w_line_pulses", w_pulse - wp0, 8);
    chk("w_line_aw_count", aw_hs - aw0, 1);

    // Simultaneous read and write
    a0 = ar_hs; aw0 = aw_hs; p0 = r_pulse; wp0 = w_pulse;
    @(negedge clk);
    ren_i = 1; raddr_i = 32'h3000_0000; rlen_i = 4'd1; rsel_i = 4'b0011;
    wen_i = 1; waddr_i = 32'h4000_0040; wlen_i = 4'd2; wsel_i = 4'b1100;
    @(negedge clk); #1;
    chk("dual_arvalid", arvalid, 1);
    chk("dual_awvalid", awvalid, 1);
    chk("dual_arsize", arsize, 1);
    chk("dual_awsize", awsize, 1);
    chk("dual_awaddr", awaddr, 32'h4000_0040);
    arready = 1; awready = 1;
    ri = 0; wi = 0; bdone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      arready = 0; awready = 0;
      ren_i  = (ri < 2);
      rvalid = (ri < 2);
      rlast  = (ri == 1);
      rdata  = $urandom;
      if (rvalid) rq.push_back(rdata);
      wready  = (wi < 3);
      wdata_i = $urandom;
      if (wready) wq.push_back(wdata_i);
      wen_i  = !bdone;
      bvalid = (wi == 3) && !bdone;
      #1;
      if (rvalid) begin
        chk("dual_rvalid_o", rdata_valid_o, 1);
        if (rq.size() > 0) chk("dual_rdata", rdata_o, rq.pop_front());
        ri++;
      end
      if (wready) begin
        chk("dual_wvalid", wvalid, 1);
        chk("dual_wstrb", wstrb, 4'hC);
        if (wq.size() > 0) chk("dual_wdata", wdata, wq.pop_front());
        wi++;
      end
      if (bvalid) begin
        chk("dual_bready", bready, 1);
        bdone = 1;
      end
    end
    rvalid = 0; rlast = 0; wready = 0; bvalid = 0; wen_i = 0; ren_i = 0;
    @(negedge clk); #1;
    chk("dual_ar_count", ar_hs - a0, 1);
    chk("dual_aw_count", aw_hs - aw0, 1);
    chk("dual_r_pulses", r_pulse - p0, 2);
    chk("dual_w_pulses", w_pulse - wp0, 3);

    // Reset during read beat 3, then fresh AR with ren_i still held
    @(negedge clk);
    ren_i = 1; raddr_i = 32'h5000_0080; rlen_i = 4'd7; rsel_i = 4'b1111;
    wait_valid(1'b0, "ar_timeout_rst");
    arready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      arready = 0; rvalid = 1; rlast = 0; rdata = $urandom;
      rq.push_back(rdata);
      #1;
      if (rq.size() > 0) chk("pre_rst_rdata", rdata_o, rq.pop_front());
    end
    @(negedge clk);
    rdata  = $urandom;
    resetn = 1'b0;
    raddr_i = 32'h5000_0100;
    #1;
    chk("mid_rst_rvalid_o", rdata_valid_o, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_rdata_o", rdata_o, 0);
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_araddr", araddr, 0);
    chk("mid_rst_arlen", arlen, 0);
    chk("mid_rst_arsize", arsize, 0);
    @(negedge clk);
    rvalid = 0;
    resetn = 1'b1;
    a0 = ar_hs; p0 = r_pulse;
    wait_valid(1'b0, "ar_timeout_after_rst");
    chk("post_rst_araddr", araddr, 32'h5000_0100);
    chk("post_rst_arlen", arlen, 7);
    arready = 1'b1;
    read_beats(8);
    @(negedge clk);
    chk("post_rst_ar_count", ar_hs - a0, 1);
    chk("post_rst_pulses", r_pulse - p0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
